alu_seq_muldiv: RTL and testbench
=================================

// Module: alu_seq_muldiv
// PURPOSE
//  Execute-stage ALU: single-cycle ops (add/sub/logic/slt) plus iterative MULT/MULTU/DIV/DIVU
//  writing HI/LO, for the MIPS datapath. Uses a start/busy/done handshake so the pipeline
//  controller can stall on long operations. Width is parameterised by bus.
// PARAMETERS
//  bus   32  operand/result width; must be >= 4
//  CNTW  6   iteration counter width; must satisfy 2**CNTW > bus
// PORTS
//  clk         in   1     single clock, rising edge
//  rst_n       in   1     synchronous, active-low reset
//  start       in   1     issue op; sampled only while busy=0
//  op          in   4     0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 MULT,9 MULTU,10 DIV,11 DIVU
//  a           in   bus   operand A (dividend / multiplicand)
//  b           in   bus   operand B (divisor / multiplier)
//  busy        out  1     multi-cycle op in progress
//  done        out  1     one-cycle pulse: result/flags valid
//  sout        out  bus   single-cycle result (held until next done)
//  hi, lo      out  bus   HI/LO registers (held until next MUL/DIV done)
//  zero        out  1     sout==0 (single-cycle) or {hi,lo}==0 (mul) or lo==0 (div)
//  cout        out  1     ADD/SUB carry-out (SUB: 1 = no borrow); 0 for other ops
//  overflow    out  1     signed overflow (ADD/SUB); DIV of -2**(bus-1) by -1
//  negative    out  1     MSB of sout, or of hi for MUL/DIV
//  div_by_zero out  1     DIV/DIVU with b==0; cleared at next done
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state IDLE; busy, done, all flags 0; sout, hi, lo = 0.
//    Reset mid-operation aborts it: no done pulse, hi/lo return to 0.
//  - FSM: IDLE -> (start & op<=7) EXEC1 result registered on same edge, done=1 next cycle, stays IDLE.
//    IDLE -> (start & op 8/9) MUL; IDLE -> (start & op 10/11) DIV; MUL/DIV -> FIN after bus
//    iterations; FIN -> IDLE with done=1. Opcodes 12-15: done pulse, no state change, all outputs held.
//  - Latency: single-cycle op accepted at edge k -> done high in cycle k+1.
//    MUL/DIV accepted at edge k -> busy=1 cycles k+1..k+bus, done=1 & busy=0 in cycle k+bus+1.
//  - start while busy=1 ignored (no queueing). Back-to-back: start is legal in the done cycle.
//  - Operands latched at accept; later changes on a/b have no effect.
//  - ADD/SUB: bus-bit two's-complement; SUB = a + ~b + 1. overflow = operand-sign rule.
//  - SLT signed, SLTU unsigned; sout = {bus-1 zeros, result}.
//  - MULT/MULTU: shift-add on magnitudes, one bit/cycle; MULT negates 2*bus product if signs differ.
//    {hi,lo} = full 2*bus-bit product.
//  - DIV/DIVU: restoring division on magnitudes, one quotient bit/cycle; lo = quotient,
//    hi = remainder. Signed: quotient truncates toward zero, remainder sign = dividend sign.
//  - b==0: no iteration; FIN next cycle (done at k+2); lo = all ones, hi = a, div_by_zero=1.
//  - DIV -2**(bus-1) / -1: lo = -2**(bus-1), hi = 0, overflow=1, full latency.
//  - MUL/DIV leave sout unchanged; single-cycle ops leave hi/lo unchanged.
// TESTING (bench at bus=8 unless stated)
//  - ADD a=8'h7F b=8'h01 -> done cycle k+1, sout=8'h80, overflow=1, negative=1, cout=0.
//  - SUB a=8'h05 b=8'h05 -> sout=0, zero=1, cout=1; SLT a=8'hFF b=8'h01 -> sout=1, SLTU -> sout=0.
//  - MULT a=-3 (8'hFD) b=7 -> busy 8 cycles, done cycle k+9, {hi,lo}=16'hFFEB; MULTU 255*255 -> hi=8'hFE lo=8'h01.
//  - DIV a=-7 b=2 -> lo=8'hFD (-3), hi=8'hFF (-1); DIVU a=200 b=0 -> done k+2, lo=8'hFF, hi=200, div_by_zero=1.
//  - DIV 8'h80 / 8'hFF -> lo=8'h80, hi=0, overflow=1; start pulsed while busy -> ignored, result unchanged.
//  - rst_n low for one edge at iteration 4 of MULT -> busy=0, hi=lo=0, no done; bus=32 random mul/div vs model.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU: single-cycle arithmetic/logic plus iterative multiply/divide into HI/LO.
// A start/busy/done handshake lets the pipeline stall while a multi-cycle op runs.
module alu_seq_muldiv #(
  parameter int bus  = 32,
  parameter int CNTW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     op,
  input  logic [bus-1:0] a,
  input  logic [bus-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [bus-1:0] sout,
  output logic [bus-1:0] hi,
  output logic [bus-1:0] lo,
  output logic           zero,
  output logic           cout,
  output logic           overflow,
  output logic           negative,
  output logic           div_by_zero
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt;
  logic [2*bus-1:0] acc;
  logic [bus-1:0]  opnd;
  logic            neg_q, neg_r, div_ovf, b_zero, done_r;
  logic            accept, last;

  assign busy   = (state == MUL) || (state == DIV);
  assign done   = done_r || (state == FIN);
  assign accept = start && !busy;
  assign last   = (cnt == CNTW'(bus - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FIN doubles as an idle state so a new op can be issued in the done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (start) begin
          if (op == OP_MULT || op == OP_MULTU)    state_nxt = MUL;
          else if (op == OP_DIV || op == OP_DIVU) state_nxt = DIV;
        end
      end
      MUL:     if (last) state_nxt = FIN;
      DIV:     if (b_zero || last) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  logic           is_signed, a_neg, b_neg;
  logic [bus-1:0] mag_a, mag_b;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed && a[bus-1];
    b_neg     = is_signed && b[bus-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
  end

  logic [bus:0]   add_full, sub_full;
  logic [bus-1:0] s_res;
  logic           s_c, s_v;

  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + (bus+1)'(1);
    s_res    = '0;
    s_c      = 1'b0;
    s_v      = 1'b0;
    case (op)
      OP_ADD: begin
        s_res = add_full[bus-1:0];
        s_c   = add_full[bus];
        s_v   = (a[bus-1] == b[bus-1]) && (add_full[bus-1] != a[bus-1]);
      end
      OP_SUB: begin
        s_res = sub_full[bus-1:0];
        s_c   = sub_full[bus];
        s_v   = (a[bus-1] != b[bus-1]) && (sub_full[bus-1] != a[bus-1]);
      end
      OP_AND:  s_res = a & b;
      OP_OR:   s_res = a | b;
      OP_XOR:  s_res = a ^ b;
      OP_NOR:  s_res = ~(a | b);
      OP_SLT:  s_res = {{(bus-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: s_res = {{(bus-1){1'b0}}, (a < b)};
      default: s_res = '0;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  logic [bus:0]     mul_sum, div_shift, div_trial;
  logic [2*bus-1:0] mul_step, div_step, prod;
  logic [bus-1:0]   quot, remd;

  always_comb begin
    mul_sum   = {1'b0, acc[2*bus-1:bus]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step  = {mul_sum, acc[bus-1:1]};
    prod      = neg_q ? -mul_step : mul_step;
    div_shift = {acc[2*bus-1:bus], acc[bus-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_step  = div_trial[bus] ? {div_shift[bus-1:0], acc[bus-2:0], 1'b0}
                               : {div_trial[bus-1:0], acc[bus-2:0], 1'b1};
    quot      = neg_q ? -div_step[bus-1:0] : div_step[bus-1:0];
    remd      = neg_r ? -div_step[2*bus-1:bus] : div_step[2*bus-1:bus];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_r      <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_ovf     <= 1'b0;
      b_zero      <= 1'b0;
      sout        <= '0;
      hi          <= '0;
      lo          <= '0;
      zero        <= 1'b0;
      cout        <= 1'b0;
      overflow    <= 1'b0;
      negative    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (accept) begin
            if (op < OP_MULT) begin
              sout        <= s_res;
              zero        <= (s_res == '0);
              cout        <= s_c;
              overflow    <= s_v;
              negative    <= s_res[bus-1];
              div_by_zero <= 1'b0;
              done_r      <= 1'b1;
            end else if (op > OP_DIVU) begin
              done_r <= 1'b1;
            end else if (op == OP_MULT || op == OP_MULTU) begin
              cnt   <= '0;
              opnd  <= mag_a;
              acc   <= {{bus{1'b0}}, mag_b};
              neg_q <= a_neg ^ b_neg;
            end else begin
              // raw dividend is kept for the divide-by-zero case, which reports hi = a
              cnt     <= '0;
              opnd    <= mag_b;
              acc     <= {{bus{1'b0}}, (b == '0) ? a : mag_a};
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              b_zero  <= (b == '0);
              div_ovf <= (op == OP_DIV) && (a == {1'b1, {(bus-1){1'b0}}}) && (b == '1);
            end
          end
        end
        MUL: begin
          cnt <= cnt + CNTW'(1);
          acc <= mul_step;
          if (last) begin
            {hi, lo}    <= prod;
            zero        <= (prod == '0);
            cout        <= 1'b0;
            overflow    <= 1'b0;
            negative    <= prod[2*bus-1];
            div_by_zero <= 1'b0;
          end
        end
        DIV: begin
          if (b_zero) begin
            lo          <= '1;
            hi          <= acc[bus-1:0];
            zero        <= 1'b0;
            cout        <= 1'b0;
            overflow    <= 1'b0;
            negative    <= acc[bus-1];
            div_by_zero <= 1'b1;
          end else begin
            cnt <= cnt + CNTW'(1);
            acc <= div_step;
            if (last) begin
              lo          <= quot;
              hi          <= remd;
              zero        <= (quot == '0);
              cout        <= 1'b0;
              overflow    <= div_ovf;
              negative    <= remd[bus-1];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench: 8-bit and 32-bit ALUs compared every cycle against an arithmetic model,
// plus hand-computed literal results and latencies.
module tb_alu_seq_muldiv;

  typedef struct {
    logic [31:0] sout, hi, lo;
    logic        zero, cout, ovf, neg, dbz;
  } res_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic [3:0] op8 = 4'd0;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       busy8, done8, zero8, cout8, ovf8, neg8, dbz8;
  logic [7:0] sout8, hi8, lo8;

  logic        start32 = 1'b0;
  logic [3:0]  op32 = 4'd0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic        busy32, done32, zero32, cout32, ovf32, neg32, dbz32;
  logic [31:0] sout32, hi32, lo32;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.bus(8), .CNTW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sout(sout8), .hi(hi8), .lo(lo8),
    .zero(zero8), .cout(cout8), .overflow(ovf8), .negative(neg8), .div_by_zero(dbz8)
  );

  alu_seq_muldiv #(.bus(32), .CNTW(6)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sout(sout32), .hi(hi32), .lo(lo32),
    .zero(zero32), .cout(cout32), .overflow(ovf32), .negative(neg32), .div_by_zero(dbz32)
  );

  int   n_cmp = 0, n_fail = 0, cyc = 0;
  bit   chk_en = 1'b0;
  bit   pend[2], multi[2];
  int   done_at[2];
  int   wid[2] = '{8, 32};
  res_t cur[2], expv[2];

  function automatic res_t zero_res();
    res_t r;
    r.sout = 0; r.hi = 0; r.lo = 0;
    r.zero = 0; r.cout = 0; r.ovf = 0; r.neg = 0; r.dbz = 0;
    return r;
  endfunction

  function automatic res_t model(int w, logic [3:0] op, logic [31:0] a, logic [31:0] b, res_t prev);
    res_t        r;
    logic [63:0] mask, ua, ub, s, pv, q, rm;
    longint      sa, sb, lim, t;
    r    = prev;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    lim  = longint'(1) << (w - 1);
    sa   = ua[w-1] ? longint'(ua) - 2 * lim : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - 2 * lim : longint'(ub);
    if (op < 4'd8) begin
      r.cout = 0; r.ovf = 0; r.dbz = 0;
      s = 0;
      case (op)
        4'd0: begin s = ua + ub; r.cout = s[w]; t = sa + sb; r.ovf = (t >= lim) || (t < -lim); end
        4'd1: begin s = ua + (~ub & mask) + 64'd1; r.cout = s[w]; t = sa - sb; r.ovf = (t >= lim) || (t < -lim); end
        4'd2: s = ua & ub;
        4'd3: s = ua | ub;
        4'd4: s = ua ^ ub;
        4'd5: s = ~(ua | ub);
        4'd6: s = (sa < sb) ? 64'd1 : 64'd0;
        default: s = (ua < ub) ? 64'd1 : 64'd0;
      endcase
      s      = s & mask;
      r.sout = s[31:0];
      r.zero = (s == 0);
      r.neg  = s[w-1];
    end else if (op < 4'd10) begin
      pv     = (op == 4'd8) ? 64'(sa * sb) : ua * ub;
      r.hi   = 32'((pv >> w) & mask);
      r.lo   = 32'(pv & mask);
      r.zero = (r.hi == 0) && (r.lo == 0);
      r.neg  = r.hi[w-1];
      r.cout = 0; r.ovf = 0; r.dbz = 0;
    end else if (op < 4'd12) begin
      r.cout = 0; r.ovf = 0; r.dbz = 0;
      if (ub == 0) begin
        q = mask; rm = ua; r.dbz = 1;
      end else if (op == 4'd10) begin
        if (sa == -lim && sb == -1) begin
          q = ua; rm = 0; r.ovf = 1;
        end else begin
          q = 64'(sa / sb); rm = 64'(sa % sb);
        end
      end else begin
        q = ua / ub; rm = ua % ub;
      end
      r.lo   = 32'(q & mask);
      r.hi   = 32'(rm & mask);
      r.zero = (r.lo == 0);
      r.neg  = r.hi[w-1];
    end
    return r;
  endfunction

  function automatic int latency(int w, logic [3:0] op, logic [31:0] b);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (op < 4'd8 || op > 4'd11) return 1;
    if (op >= 4'd10 && (b & m) == 0) return 2;
    return w + 1;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h want %h", name, wid[d], cyc, act, want);
    end
  endtask

  // every cycle: handshake against the model schedule, all held outputs against the model
  initial begin
    bit   e_done, e_busy, a_busy, a_done;
    res_t act;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          e_done = pend[d] && (cyc == done_at[d]);
          e_busy = pend[d] && multi[d] && (cyc < done_at[d]);
          if (e_done) begin
            cur[d]  = expv[d];
            pend[d] = 1'b0;
          end
          if (d == 0) begin
            a_busy = busy8; a_done = done8;
            act.sout = 32'(sout8); act.hi = 32'(hi8); act.lo = 32'(lo8);
            act.zero = zero8; act.cout = cout8; act.ovf = ovf8; act.neg = neg8; act.dbz = dbz8;
          end else begin
            a_busy = busy32; a_done = done32;
            act.sout = sout32; act.hi = hi32; act.lo = lo32;
            act.zero = zero32; act.cout = cout32; act.ovf = ovf32; act.neg = neg32; act.dbz = dbz32;
          end
          check("busy", d, 32'(a_busy), 32'(e_busy));
          check("done", d, 32'(a_done), 32'(e_done));
          check("sout", d, act.sout, cur[d].sout);
          check("hi",   d, act.hi,   cur[d].hi);
          check("lo",   d, act.lo,   cur[d].lo);
          check("zero", d, 32'(act.zero), 32'(cur[d].zero));
          check("cout", d, 32'(act.cout), 32'(cur[d].cout));
          check("overflow", d, 32'(act.ovf), 32'(cur[d].ovf));
          check("negative", d, 32'(act.neg), 32'(cur[d].neg));
          check("div_by_zero", d, 32'(act.dbz), 32'(cur[d].dbz));
        end
      end
    end
  end

  task automatic apply_stimulus(input int d, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output bit acc);
    int lat;
    @(negedge clk);
    if (d == 0) begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else        begin start32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    @(posedge clk);
    acc = !(pend[d] && multi[d]);
    if (acc) begin
      lat        = latency(wid[d], op, b);
      expv[d]    = model(wid[d], op, a, b, cur[d]);
      multi[d]   = (lat > 1);
      done_at[d] = cyc + lat;
      pend[d]    = 1'b1;
    end
    #1;
    if (d == 0) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
    else        begin start32 = 1'b0; a32 = $urandom; b32 = $urandom; end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (pend[d] && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (pend[d]) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL wait_idle dut%0d: op still pending after %0d cycles", wid[d], n);
    end
  endtask

  task automatic run(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    apply_stimulus(d, op, a, b, acc);
    wait_idle(d);
  endtask

  // cycles from the accepting edge until done8 is seen, counting the first cycle as 1
  task automatic measure(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    bit acc;
    apply_stimulus(0, op, {24'd0, a}, {24'd0, b}, acc);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    wait_idle(0);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    check(name, 0, act, want);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  lat;
    bit  acc;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    for (int d = 0; d < 2; d++) begin
      cur[d] = zero_res(); expv[d] = zero_res();
      pend[d] = 1'b0; multi[d] = 1'b0; done_at[d] = 0;
    end

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check_output("reset_busy", 32'(busy8), 32'd0);
    check_output("reset_sout", 32'(sout8), 32'd0);
    check_output("reset_hi",   32'(hi8),   32'd0);

    measure(4'd0, 8'h7F, 8'h01, lat);
    check_output("add_latency", lat, 1);
    check_output("add_sout", 32'(sout8), 32'h80);
    check_output("add_ovf",  32'(ovf8),  32'd1);
    check_output("add_neg",  32'(neg8),  32'd1);
    check_output("add_cout", 32'(cout8), 32'd0);

    run(0, 4'd1, 32'h05, 32'h05);
    check_output("sub_sout", 32'(sout8), 32'd0);
    check_output("sub_zero", 32'(zero8), 32'd1);
    check_output("sub_cout", 32'(cout8), 32'd1);

    apply_stimulus(0, 4'd6, 32'hFF, 32'h01, acc);
    check_output("slt_sout", 32'(sout8), 32'd1);
    apply_stimulus(0, 4'd7, 32'hFF, 32'h01, acc);
    wait_idle(0);
    check_output("sltu_sout", 32'(sout8), 32'd0);

    measure(4'd8, 8'hFD, 8'h07, lat);
    check_output("mult_latency", lat, 9);
    check_output("mult_hi", 32'(hi8), 32'hFF);
    check_output("mult_lo", 32'(lo8), 32'hEB);

    run(0, 4'd9, 32'hFF, 32'hFF);
    check_output("multu_hi", 32'(hi8), 32'hFE);
    check_output("multu_lo", 32'(lo8), 32'h01);

    run(0, 4'd10, 32'hF9, 32'h02);
    check_output("div_lo", 32'(lo8), 32'hFD);
    check_output("div_hi", 32'(hi8), 32'hFF);

    measure(4'd11, 8'd200, 8'h00, lat);
    check_output("divu0_latency", lat, 2);
    check_output("divu0_lo",  32'(lo8),  32'hFF);
    check_output("divu0_hi",  32'(hi8),  32'd200);
    check_output("divu0_dbz", 32'(dbz8), 32'd1);

    apply_stimulus(0, 4'd10, 32'h80, 32'hFF, acc);
    apply_stimulus(0, 4'd0, 32'h01, 32'h01, acc);
    wait_idle(0);
    check_output("divovf_lo",   32'(lo8),   32'h80);
    check_output("divovf_hi",   32'(hi8),   32'h00);
    check_output("divovf_ovf",  32'(ovf8),  32'd1);
    check_output("divovf_dbz",  32'(dbz8),  32'd0);
    check_output("ignored_add", 32'(sout8), 32'd0);

    run(0, 4'd13, 32'h12, 32'h34);
    check_output("illegal_hold_lo", 32'(lo8), 32'h80);

    run(0, 4'd9, 32'hFF, 32'hFF);
    apply_stimulus(0, 4'd8, 32'hFD, 32'h07, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0; multi[d] = 1'b0; cur[d] = zero_res();
    end
    #1;
    check_output("abort_busy", 32'(busy8), 32'd0);
    check_output("abort_hi",   32'(hi8),   32'd0);
    check_output("abort_lo",   32'(lo8),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 6 == 5) ? 32'd0 : $urandom;
      run(0, rop, ra, rb);
    end

    run(1, 4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div32_ovf_lo", 1, lo32, 32'h8000_0000);
    check("div32_ovf_flag", 1, 32'(ovf32), 32'd1);
    run(1, 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult32_lo", 1, lo32, 32'd1);
    for (int i = 0; i < 20; i++) begin
      rop = 4'($urandom_range(8, 11));
      ra  = $urandom;
      rb  = (i % 7 == 3) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      run(1, rop, ra, rb);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
